wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock, ip_clk; ip_rst is synchronous and active-high.
REQ-002 ip_clk  in  1  system clock; all state updates on rising edge.
REQ-003 ip_rst  in  1  synchronous active-high reset.
REQ-004 ip_alu_valid  in  1  single-cycle ALU result present this cycle.
REQ-005 ip_alu_rd_addr  in  5  ALU destination register.
REQ-006 ip_alu_data  in  32  ALU result.
REQ-007 ip_mdu_issue  in  1  MUL/DIV op accepted by MDU this cycle.
REQ-008 ip_mdu_issue_rd  in  5  destination of the issued MDU op.
REQ-009 ip_mdu_valid  in  1  MDU result offered.
REQ-010 ip_mdu_rd_addr  in  5  MDU result destination.
REQ-011 ip_mdu_data  in  32  MDU result.
REQ-012 op_mdu_ready  out  1  arbiter can accept an MDU result.
REQ-013 ip_rs1_addr, ip_rs2_addr  in  5 each  decode-stage source registers.
REQ-014 op_wr_en  out  1  register-file write enable, registered.
REQ-015 op_rd_addr  out  5  register-file write address, registered.
REQ-016 op_wr_data  out  32  register-file write data, registered.
REQ-017 op_stall  out  1  decode must hold; combinational.
REQ-018 op_busy_vec  out  32  scoreboard, bit n = xn has an MDU result outstanding.

Function
REQ-019 An MDU transfer SHALL occur only in a cycle with ip_mdu_valid=1 and op_mdu_ready=1.
REQ-020 op_mdu_ready SHALL be 1 exactly when the 1-entry hold register is empty and ip_rst=0.
REQ-021 Write-slot priority per cycle: (1) ALU with rd!=0, (2) hold entry, (3) MDU transfer with rd!=0.
REQ-022 The winning source SHALL appear on op_wr_en/op_rd_addr/op_wr_data at the next rising edge (latency 1); op_wr_en=0 if no source wins.
REQ-023 An MDU transfer that does not win the slot SHALL be captured into the hold register.
REQ-024 The hold entry SHALL drain in the first cycle with no ALU write (ALU valid with rd=0 counts as no ALU write).
REQ-025 Writes to x0 SHALL never assert op_wr_en. An x0 MDU transfer SHALL be accepted and discarded without using the hold register.
REQ-026 op_wr_data/op_rd_addr SHALL hold their last values when op_wr_en=0.
REQ-027 Scoreboard set: ip_mdu_issue with ip_mdu_issue_rd!=0 SHALL set that bit at the next edge.
REQ-028 Scoreboard clear: at the edge ending a cycle in which op_wr_en=1 carries an MDU-sourced write to xn, bit n SHALL clear.
REQ-029 A simultaneous set and clear of the same bit SHALL leave it set.
REQ-030 Bit 0 of op_busy_vec SHALL be constant 0.
REQ-031 op_stall SHALL be op_busy_vec[ip_rs1_addr] | op_busy_vec[ip_rs2_addr] | (ip_mdu_issue & hold full).
REQ-032 ALU write to a register whose busy bit is set SHALL still be performed; WAW ordering is decode's responsibility via op_stall.

Reset
REQ-033 While ip_rst=1 at an edge: op_wr_en=0, op_rd_addr=0, op_wr_data=0, op_busy_vec=0, hold empty.
REQ-034 op_mdu_ready SHALL be 0 during reset and 1 in the first cycle after ip_rst falls.
REQ-035 Reset mid-operation SHALL discard the hold entry and all pending busy bits; no write SHALL occur for them afterward.

Verification
REQ-036 ALU only: ALU valid rd=5 data=0x1 -> next cycle op_wr_en=1, rd=5, data=0x00000001.
REQ-037 Collision: ALU rd=6 data=0x2 and MDU transfer rd=7 data=0x3 in the same cycle -> cycle+1 writes x6=0x2 with op_mdu_ready=0; cycle+2 writes x7=0x3 with op_mdu_ready=1.
REQ-038 Hold blocked: hold full and ALU valid for 3 consecutive cycles -> op_mdu_ready=0 throughout; the hold entry is written in the cycle after the ALU stream ends.
REQ-039 Scoreboard: issue rd=8, then rs1=8 -> op_stall=1 until the cycle after the x8 MDU write (data 0x4) is on op_wr_en, then 0; op_busy_vec[8] tracks the same.
REQ-040 x0: ALU rd=0 and MDU rd=0 -> op_wr_en stays 0 and op_busy_vec stays 0.
REQ-041 Reset mid-op: hold full and busy[9]=1, assert ip_rst for one cycle -> all outputs 0 and no later write to x9.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of the ALU/MDU result paths, register-file write port and
// decode-stage hazard signals that surround the writeback arbiter.
interface wb_arbiter_if;
  logic        ip_alu_valid;
  logic [4:0]  ip_alu_rd_addr;
  logic [31:0] ip_alu_data;
  logic        ip_mdu_issue;
  logic [4:0]  ip_mdu_issue_rd;
  logic        ip_mdu_valid;
  logic [4:0]  ip_mdu_rd_addr;
  logic [31:0] ip_mdu_data;
  logic        op_mdu_ready;
  logic [4:0]  ip_rs1_addr;
  logic [4:0]  ip_rs2_addr;
  logic        op_wr_en;
  logic [4:0]  op_rd_addr;
  logic [31:0] op_wr_data;
  logic        op_stall;
  logic [31:0] op_busy_vec;

  // Pipeline side: produces results and source addresses, consumes writes.
  modport master (
    output ip_alu_valid, ip_alu_rd_addr, ip_alu_data,
    output ip_mdu_issue, ip_mdu_issue_rd,
    output ip_mdu_valid, ip_mdu_rd_addr, ip_mdu_data,
    output ip_rs1_addr, ip_rs2_addr,
    input  op_mdu_ready, op_wr_en, op_rd_addr, op_wr_data, op_stall, op_busy_vec
  );

  // Arbiter side.
  modport slave (
    input  ip_alu_valid, ip_alu_rd_addr, ip_alu_data,
    input  ip_mdu_issue, ip_mdu_issue_rd,
    input  ip_mdu_valid, ip_mdu_rd_addr, ip_mdu_data,
    input  ip_rs1_addr, ip_rs2_addr,
    output op_mdu_ready, op_wr_en, op_rd_addr, op_wr_data, op_stall, op_busy_vec
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and multi-cycle MDU
// results onto one register-file write port. A one-entry hold register
// parks an MDU result that loses the slot to the ALU; a busy scoreboard
// tracks destinations of in-flight MDU ops so decode can stall.
module wb_arbiter (
  input  logic         ip_clk,
  input  logic         ip_rst,
  wb_arbiter_if.slave  bus
);

  logic        wr_en_q,      wr_en_d;
  logic        wr_mdu_q,     wr_mdu_d;
  logic [4:0]  rd_addr_q,    rd_addr_d;
  logic [31:0] wr_data_q,    wr_data_d;
  logic        hold_valid_q, hold_valid_d;
  logic [4:0]  hold_rd_q,    hold_rd_d;
  logic [31:0] hold_data_q,  hold_data_d;
  logic [31:0] busy_q,       busy_d;

  logic        mdu_ready;
  logic        alu_wr;
  logic        mdu_wr;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Hand-shake qualifiers; x0 destinations never compete for the slot.
  always_comb begin
    mdu_ready = ~hold_valid_q & ~ip_rst;
    alu_wr    = bus.ip_alu_valid & (bus.ip_alu_rd_addr != 5'd0);
    mdu_wr    = bus.ip_mdu_valid & mdu_ready & (bus.ip_mdu_rd_addr != 5'd0);
  end

  // Write-slot priority: ALU, then parked hold entry, then fresh MDU result.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_mdu_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_data_d    = wr_data_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    if (alu_wr) begin
      wr_en_d   = 1'b1;
      rd_addr_d = bus.ip_alu_rd_addr;
      wr_data_d = bus.ip_alu_data;
    end else if (hold_valid_q) begin
      wr_en_d      = 1'b1;
      wr_mdu_d     = 1'b1;
      rd_addr_d    = hold_rd_q;
      wr_data_d    = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (mdu_wr) begin
      wr_en_d   = 1'b1;
      wr_mdu_d  = 1'b1;
      rd_addr_d = bus.ip_mdu_rd_addr;
      wr_data_d = bus.ip_mdu_data;
    end
    // An accepted MDU result can only lose to the ALU (hold is empty then).
    if (mdu_wr && alu_wr) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = bus.ip_mdu_rd_addr;
      hold_data_d  = bus.ip_mdu_data;
    end
  end

  // Scoreboard: set on issue, clear once the MDU write is on the port;
  // set wins over clear, and x0 is never tracked.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.ip_mdu_issue && (bus.ip_mdu_issue_rd != 5'd0))
      set_mask[bus.ip_mdu_issue_rd] = 1'b1;
    if (wr_en_q && wr_mdu_q)
      clr_mask[rd_addr_q] = 1'b1;
    busy_d = ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  // State registers with synchronous reset.
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      wr_en_q      <= 1'b0;
      wr_mdu_q     <= 1'b0;
      rd_addr_q    <= 5'd0;
      wr_data_q    <= 32'd0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= 5'd0;
      hold_data_q  <= 32'd0;
      busy_q       <= 32'd0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_mdu_q     <= wr_mdu_d;
      rd_addr_q    <= rd_addr_d;
      wr_data_q    <= wr_data_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      busy_q       <= busy_d;
    end
  end

  // Output drive; stall looks at the live scoreboard and hold occupancy.
  always_comb begin
    bus.op_mdu_ready = mdu_ready;
    bus.op_wr_en     = wr_en_q;
    bus.op_rd_addr   = rd_addr_q;
    bus.op_wr_data   = wr_data_q;
    bus.op_busy_vec  = busy_q;
    bus.op_stall     = busy_q[bus.ip_rs1_addr] | busy_q[bus.ip_rs2_addr] |
                       (bus.ip_mdu_issue & hold_valid_q);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random stimulus for the writeback arbiter, checked against
// a queue-based model of the write slot, hold buffer and scoreboard.
module tb_wb_arbiter;
  logic ip_clk = 1'b0;
  logic ip_rst = 1'b1;
  always #5 ip_clk = ~ip_clk;

  wb_arbiter_if bus ();
  wb_arbiter dut (.ip_clk(ip_clk), .ip_rst(ip_rst), .bus(bus));

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  int n_vec = 0;
  int n_err = 0;

  ent_t        pend[$];     // MDU results accepted but not yet written
  logic [31:0] m_busy  = '0;
  logic        m_wr_en = 1'b0;
  logic        m_wr_mdu = 1'b0;
  logic [4:0]  m_rd    = '0;
  logic [31:0] m_data  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic iss, input logic [4:0] ird,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    logic        rdy, stall, xfer;
    logic [31:0] nbusy;
    logic        n_en, n_mdu;
    logic [4:0]  n_rd;
    logic [31:0] n_data;
    ent_t        e;
    ip_rst              = rst;
    bus.ip_alu_valid    = av;
    bus.ip_alu_rd_addr  = ard;
    bus.ip_alu_data     = ad;
    bus.ip_mdu_issue    = iss;
    bus.ip_mdu_issue_rd = ird;
    bus.ip_mdu_valid    = mv;
    bus.ip_mdu_rd_addr  = mrd;
    bus.ip_mdu_data     = md;
    bus.ip_rs1_addr     = rs1;
    bus.ip_rs2_addr     = rs2;
    #1;
    rdy   = !rst && (pend.size() == 0);
    stall = m_busy[rs1] | m_busy[rs2] | (iss && pend.size() != 0);
    chk({tag, ".ready"}, 32'(bus.op_mdu_ready), 32'(rdy));
    chk({tag, ".stall"}, 32'(bus.op_stall), 32'(stall));

    n_en = 1'b0; n_mdu = 1'b0; n_rd = m_rd; n_data = m_data;
    nbusy = m_busy;
    if (rst) begin
      pend.delete();
      nbusy = '0; n_rd = '0; n_data = '0;
    end else begin
      xfer = mv && rdy;
      if (m_wr_en && m_wr_mdu) nbusy[m_rd] = 1'b0;
      if (iss && ird != 0) nbusy[ird] = 1'b1;
      nbusy[0] = 1'b0;
      if (xfer && mrd != 0) pend.push_back(ent_t'{rd: mrd, d: md});
      if (av && ard != 0) begin
        n_en = 1'b1; n_rd = ard; n_data = ad;
      end else if (pend.size() != 0) begin
        e = pend.pop_front();
        n_en = 1'b1; n_mdu = 1'b1; n_rd = e.rd; n_data = e.d;
      end
    end
    @(posedge ip_clk);
    m_wr_en = n_en; m_wr_mdu = n_mdu; m_rd = n_rd; m_data = n_data; m_busy = nbusy;
    #1;
    chk({tag, ".wr_en"}, 32'(bus.op_wr_en), 32'(m_wr_en));
    chk({tag, ".rd"},    32'(bus.op_rd_addr), 32'(m_rd));
    chk({tag, ".data"},  bus.op_wr_data, m_data);
    chk({tag, ".busy"},  bus.op_busy_vec, m_busy);
  endtask

  task automatic idle(input string tag, input logic [4:0] rs1);
    step(tag, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, rs1, 5'd0);
  endtask

  initial begin
    bus.ip_alu_valid = 1'b0; bus.ip_alu_rd_addr = '0; bus.ip_alu_data = '0;
    bus.ip_mdu_issue = 1'b0; bus.ip_mdu_issue_rd = '0;
    bus.ip_mdu_valid = 1'b0; bus.ip_mdu_rd_addr = '0; bus.ip_mdu_data = '0;
    bus.ip_rs1_addr = '0; bus.ip_rs2_addr = '0;
    repeat (2) @(posedge ip_clk);
    #1;

    // Reset state
    step("rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle("post_rst", 5'd0);

    // ALU only
    step("alu", 1'b0, 1'b1, 5'd5, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("alu.lit_rd", 32'(bus.op_rd_addr), 32'd5);
    chk("alu.lit_data", bus.op_wr_data, 32'h1);
    idle("alu_idle", 5'd0);

    // Collision: ALU x6 wins, MDU x7 parked then drained
    step("coll", 1'b0, 1'b1, 5'd6, 32'h2, 1'b0, 5'd0, 1'b1, 5'd7, 32'h3, 5'd0, 5'd0);
    chk("coll.lit_x6", bus.op_wr_data, 32'h2);
    idle("coll2", 5'd0);
    chk("coll2.lit_x7", 32'(bus.op_rd_addr), 32'd7);
    idle("coll3", 5'd0);

    // Hold blocked by a 3-cycle ALU stream, MDU keeps offering
    step("blk0", 1'b0, 1'b1, 5'd1, 32'hA, 1'b0, 5'd0, 1'b1, 5'd2, 32'hB, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      step("blk", 1'b0, 1'b1, 5'(3 + i), 32'(i), 1'b1, 5'd0, 1'b1, 5'd4, 32'hC, 5'd0, 5'd0);
    idle("blk_drain", 5'd0);
    chk("blk.lit_x2", bus.op_wr_data, 32'hB);
    idle("blk_end", 5'd0);

    // Scoreboard on x8
    step("sb_iss", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
    idle("sb_wait", 5'd8);
    step("sb_wr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h4, 5'd8, 5'd0);
    idle("sb_onport", 5'd8);
    idle("sb_clear", 5'd8);
    chk("sb.lit_stall0", 32'(bus.op_stall), 32'd0);

    // x0 destinations
    step("x0", 1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
    idle("x0b", 5'd0);

    // Reset mid-op: busy[9] set, hold full, then reset
    step("rm_iss", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step("rm_fill", 1'b0, 1'b1, 5'd1, 32'h7, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9, 5'd0, 5'd0);
    step("rm_rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    for (int i = 0; i < 3; i++) idle("rm_after", 5'd9);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step("rnd", 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
